// File: rtl/pipeline_pkg.sv
// Shared definitions for the fetch/decode boundary of the pipelined core.
// Holds the datapath width, the bubble instruction and the fetch pair type.
package pipeline_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_plus_4;
  } if_id_entry_t;

  // Eight-bit add that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [7:0] inc);
    logic [8:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// Register array behind the fetch/decode queue: one write port and one
// asynchronous read port. No reset, since contents are qualified by the occupancy count.
module if_id_queue_mem #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// In-order fetch-to-decode buffer with valid/ready on both sides, flush on
// taken branches and a saturating count of entries lost to flushes.
module if_id_queue #(
  parameter int              XLEN      = pipeline_pkg::XLEN,
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(pipeline_pkg::NOP_INSTR),
  parameter int              AW        = $clog2(DEPTH),
  parameter int              CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_instruction,
  input  logic [XLEN-1:0]  if_pc_plus_4,
  output logic             if_ready,
  input  logic             flush,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_instruction,
  output logic [XLEN-1:0]  id_pc_plus_4,
  output logic [XLEN-1:0]  id_pc,
  input  logic             id_ready,
  output logic [CNT_W-1:0] count,
  output logic [7:0]       drop_count
);

  import pipeline_pkg::*;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              push;
  logic              pop;
  logic [2*XLEN-1:0] head;
  logic [XLEN-1:0]   head_pc4;

  // Ready depends only on registered occupancy and flush, never on id_ready.
  assign if_ready = (count != FULL) && !flush;
  assign id_valid = (count != '0);
  assign push     = if_valid && if_ready;
  assign pop      = id_valid && id_ready && !flush;

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({if_instruction, if_pc_plus_4}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign head_pc4       = head[XLEN-1:0];
  assign id_instruction = id_valid ? head[2*XLEN-1:XLEN] : NOP_INSTR;
  assign id_pc_plus_4   = id_valid ? head_pc4 : '0;
  assign id_pc          = id_valid ? (head_pc4 - XLEN'(4)) : '0;

  // Flush wins over push and pop and folds the discarded entries into drop_count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_count <= sat_add8(drop_count, 8'(count));
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a vector table for the handshake and flush
// cases, then hand-written reset, saturation and wrap-around sequences.
module tb_if_id_queue;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc_plus_4;
  logic        if_ready;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_plus_4;
  logic [31:0] id_pc;
  logic        id_ready;
  logic [1:0]  count;
  logic [7:0]  drop_count;

  int checks_total;
  int checks_passed;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        fl;
    logic        rdy;
    logic        e_if_ready;
    logic        e_id_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [31:0] e_pc;
    logic [1:0]  e_count;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs [15];

  if_id_queue dut (
    .clk            (clk),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc_plus_4   (if_pc_plus_4),
    .if_ready       (if_ready),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_pc_plus_4   (id_pc_plus_4),
    .id_pc          (id_pc),
    .id_ready       (id_ready),
    .count          (count),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc4,
                       input logic fl, input logic rdy);
    if_valid       = v;
    if_instruction = instr;
    if_pc_plus_4   = pc4;
    flush          = fl;
    id_ready       = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one row, check pre-edge outputs, then clock it in.
  task automatic apply_stimulus(input int idx);
    vec_t r;
    string tag;
    r = vecs[idx];
    tag = $sformatf("vec%0d", idx);
    drive(r.v, r.instr, r.pc4, r.fl, r.rdy);
    #2;
    check_output({tag, ".if_ready"}, 32'(if_ready), 32'(r.e_if_ready));
    check_output({tag, ".id_valid"}, 32'(id_valid), 32'(r.e_id_valid));
    check_output({tag, ".id_instruction"}, id_instruction, r.e_instr);
    check_output({tag, ".id_pc_plus_4"}, id_pc_plus_4, r.e_pc4);
    check_output({tag, ".id_pc"}, id_pc, r.e_pc);
    check_output({tag, ".count"}, 32'(count), 32'(r.e_count));
    check_output({tag, ".drop_count"}, 32'(drop_count), 32'(r.e_drop));
    tick();
  endtask

  initial begin
    int sent;
    int got;
    int idx_q[$];
    int e;

    checks_total  = 0;
    checks_passed = 0;

    //          v  instr          pc4            fl rdy  ir iv e_instr        e_pc4          e_pc           cnt drop
    vecs[0]  = '{1, 32'hA000_0001, 32'h0000_0004, 0, 0,  1, 0, 32'h0,         32'h0,         32'h0,         0, 0};
    vecs[1]  = '{1, 32'hB000_0002, 32'h0000_0008, 0, 0,  1, 1, 32'hA000_0001, 32'h0000_0004, 32'h0000_0000, 1, 0};
    vecs[2]  = '{1, 32'hC000_0003, 32'h0000_000C, 0, 0,  0, 1, 32'hA000_0001, 32'h0000_0004, 32'h0000_0000, 2, 0};
    vecs[3]  = '{1, 32'hC000_0003, 32'h0000_000C, 0, 1,  0, 1, 32'hA000_0001, 32'h0000_0004, 32'h0000_0000, 2, 0};
    vecs[4]  = '{1, 32'hC000_0003, 32'h0000_000C, 0, 0,  1, 1, 32'hB000_0002, 32'h0000_0008, 32'h0000_0004, 1, 0};
    vecs[5]  = '{0, 32'h0,         32'h0,         0, 1,  0, 1, 32'hB000_0002, 32'h0000_0008, 32'h0000_0004, 2, 0};
    vecs[6]  = '{1, 32'hD000_0004, 32'h0000_0010, 0, 1,  1, 1, 32'hC000_0003, 32'h0000_000C, 32'h0000_0008, 1, 0};
    vecs[7]  = '{0, 32'h0,         32'h0,         0, 0,  1, 1, 32'hD000_0004, 32'h0000_0010, 32'h0000_000C, 1, 0};
    vecs[8]  = '{1, 32'hE000_0005, 32'h0000_0014, 0, 0,  1, 1, 32'hD000_0004, 32'h0000_0010, 32'h0000_000C, 1, 0};
    vecs[9]  = '{1, 32'hF000_0006, 32'h0000_0018, 1, 1,  0, 1, 32'hD000_0004, 32'h0000_0010, 32'h0000_000C, 2, 0};
    vecs[10] = '{0, 32'h0,         32'h0,         0, 1,  1, 0, 32'h0,         32'h0,         32'h0,         0, 2};
    vecs[11] = '{1, 32'h1234_5678, 32'h0000_0000, 0, 0,  1, 0, 32'h0,         32'h0,         32'h0,         0, 2};
    vecs[12] = '{0, 32'h0,         32'h0,         0, 0,  1, 1, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFC, 1, 2};
    vecs[13] = '{0, 32'h0,         32'h0,         1, 0,  0, 1, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFC, 1, 2};
    vecs[14] = '{0, 32'h0,         32'h0,         0, 0,  1, 0, 32'h0,         32'h0,         32'h0,         0, 3};

    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_output("reset.if_ready", 32'(if_ready), 32'd1);
    check_output("reset.id_valid", 32'(id_valid), 32'd0);
    check_output("reset.id_instruction", id_instruction, 32'h0);
    check_output("reset.count", 32'(count), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(i);
    end

    // Asynchronous reset mid-stream with two entries held.
    drive(1, 32'h7000_0001, 32'h0000_0040, 0, 0);
    tick();
    drive(1, 32'h7000_0002, 32'h0000_0044, 0, 0);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0);
    #2;
    check_output("midreset.pre_count", 32'(count), 32'd2);
    reset = 1'b0;
    #1;
    check_output("midreset.count", 32'(count), 32'd0);
    check_output("midreset.id_valid", 32'(id_valid), 32'd0);
    check_output("midreset.id_instruction", id_instruction, 32'h0);
    check_output("midreset.if_ready", 32'(if_ready), 32'd1);
    check_output("midreset.drop_count", 32'(drop_count), 32'd0);
    @(posedge clk);
    #1;
    drive(1, 32'h7000_0003, 32'h0000_0048, 0, 0);
    reset = 1'b1;
    tick();
    drive(0, 32'h0, 32'h0, 0, 0);
    #1;
    check_output("release.count", 32'(count), 32'd1);
    check_output("release.id_instruction", id_instruction, 32'h7000_0003);
    check_output("release.id_pc", id_pc, 32'h0000_0044);

    // Clear the leftover entry, then 130 flushes of a full queue.
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();
    check_output("sat.start", 32'(drop_count), 32'd1);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    for (int f = 1; f <= 130; f++) begin
      drive(1, 32'h8000_0000 + 32'(f), 32'h0000_0100, 0, 0);
      tick();
      tick();
      drive(0, 32'h0, 32'h0, 1, 0);
      tick();
      if (f == 127) check_output("sat.after127", 32'(drop_count), 32'd254);
      if (f == 128) check_output("sat.after128", 32'(drop_count), 32'd255);
    end
    check_output("sat.after130", 32'(drop_count), 32'd255);
    check_output("sat.count", 32'(count), 32'd0);

    // Stream eight pairs with id_ready toggling; scoreboard checks order.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      drive(sent < 8, 32'h5000_0000 + 32'(sent), 32'h0000_0100 + 32'(4 * sent), 0, cyc[0]);
      #2;
      if (id_valid && id_ready) begin
        if (idx_q.size() == 0) begin
          check_output("wrap.unexpected_pop", id_instruction, 32'hDEAD_DEAD);
        end else begin
          e = idx_q.pop_front();
          check_output($sformatf("wrap.instr%0d", e), id_instruction, 32'h5000_0000 + 32'(e));
          check_output($sformatf("wrap.pc%0d", e), id_pc, 32'h0000_00FC + 32'(4 * e));
        end
        got++;
      end
      if (if_valid && if_ready) begin
        idx_q.push_back(sent);
        sent++;
      end
      tick();
    end
    drive(0, 32'h0, 32'h0, 0, 0);
    check_output("wrap.received", 32'(got), 32'd8);
    check_output("wrap.final_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
